// File: rtl/pc_pkg.sv
// Shared encodings for the program counter / return-address stack unit:
// operation codes, control FSM states and fault codes.
package pc_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_BRZ  = 3'b010;
  localparam logic [2:0] OP_BRNZ = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } pc_state_e;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;

endpackage

// File: rtl/pc_ras_unit_ras_stack.sv
// LIFO of return addresses. Only the occupancy count is reset; entry
// contents are don't-care until written. Callers must not push when full
// or pop when empty.
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] DEPTH_VAL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    wr_idx, top_idx;
  logic [CW-1:0]    top_pos;

  // Write slot is the current count; top entry sits one below it.
  assign top_pos = count_q - ONE;
  assign wr_idx  = count_q[IW-1:0];
  assign top_idx = top_pos[IW-1:0];

  assign full  = (count_q == DEPTH_VAL);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign top   = mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    if (push && !full) begin
      count_d = count_q + ONE;
    end else if (pop && !empty) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with call/return stack: sequential, relative branch,
// absolute jump, call/return, stall and a sticky fault state left only by reset.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int                  ADDR_WIDTH   = 16,
  parameter int                  OFFSET_WIDTH = 8,
  parameter int                  RAS_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     op,
  input  logic                           zero,
  input  logic [OFFSET_WIDTH-1:0]        offset,
  input  logic [ADDR_WIDTH-1:0]          target,
  output logic [ADDR_WIDTH-1:0]          instr_addr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           fault,
  output logic [1:0]                     fault_code,
  output logic [1:0]                     dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  pc_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  fault_q, fault_d;
  logic [1:0]            code_q, code_d;

  logic [ADDR_WIDTH-1:0] pc_inc, pc_rel, ras_top;
  logic                  push, pop, ras_full, ras_empty;

  assign pc_inc = pc_q + ONE;
  assign pc_rel = pc_q + {{(ADDR_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};

  ras_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    code_d  = code_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          case (op)
            OP_NOP:  pc_d = pc_q;
            OP_BRZ:  pc_d = zero ? pc_rel : pc_inc;
            OP_BRNZ: pc_d = zero ? pc_inc : pc_rel;
            OP_JMP:  pc_d = target;
            OP_CALL: begin
              // Overflow freezes the PC where the offending call sits.
              if (ras_full) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
                code_d  = FC_OVERFLOW;
              end else begin
                push = 1'b1;
                pc_d = target;
              end
            end
            OP_RET: begin
              if (ras_empty) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
                code_d  = FC_UNDERFLOW;
              end else begin
                pop  = 1'b1;
                pc_d = ras_top;
              end
            end
            default: pc_d = pc_inc;
          endcase
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign instr_addr = pc_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: a vector table of single-cycle operations
// plus hand-written reset, underflow and mid-stall reset sequences.
module tb_pc_ras_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  op = OP_NOP;
  logic        zero = 1'b0;
  logic [7:0]  offset = '0;
  logic [15:0] target = '0;
  logic [15:0] instr_addr;
  logic [2:0]  ras_count;
  logic        fault;
  logic [1:0]  fault_code;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        zero;
    logic [7:0]  offset;
    logic [15:0] target;
    logic [15:0] exp_pc;
    logic [2:0]  exp_count;
    logic        exp_fault;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs [64];
  int   n_vecs = 0;

  pc_ras_unit #(
    .ADDR_WIDTH   (16),
    .OFFSET_WIDTH (8),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .op         (op),
    .zero       (zero),
    .offset     (offset),
    .target     (target),
    .instr_addr (instr_addr),
    .ras_count  (ras_count),
    .fault      (fault),
    .fault_code (fault_code),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [15:0] pc, input logic [2:0] cnt,
                           input logic flt, input logic [1:0] code);
    chk({name, " pc"}, 32'(instr_addr), 32'(pc));
    chk({name, " count"}, 32'(ras_count), 32'(cnt));
    chk({name, " fault"}, 32'(fault), 32'(flt));
    chk({name, " code"}, 32'(fault_code), 32'(code));
  endtask

  task automatic add(input logic st, input logic [2:0] o, input logic z, input logic [7:0] off,
                     input logic [15:0] tgt, input logic [15:0] pc, input logic [2:0] cnt,
                     input logic flt, input logic [1:0] code);
    vecs[n_vecs] = '{st, o, z, off, tgt, pc, cnt, flt, code};
    n_vecs++;
  endtask

  // Inputs change on the falling edge; results are sampled one falling edge later.
  task automatic apply(input vec_t v, input string name);
    stall  = v.stall;
    op     = v.op;
    zero   = v.zero;
    offset = v.offset;
    target = v.target;
    @(negedge clk);
    chk_state(name, v.exp_pc, v.exp_count, v.exp_fault, v.exp_code);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_state({name, " async"}, 16'h0000, 3'd0, 1'b0, FC_NONE);
    @(negedge clk);
    stall  = 1'b0;
    op     = OP_JMP;
    target = 16'h0ABC;
    reset  = 1'b1;
    @(negedge clk);
    chk_state({name, " boot"}, 16'h0000, 3'd0, 1'b0, FC_NONE);
  endtask

  initial begin
    vec_t v;

    add(0, OP_JMP,  0, 8'h00, 16'h0010, 16'h0010, 0, 0, FC_NONE);
    add(0, OP_BRZ,  1, 8'hF8, 16'h0000, 16'h0008, 0, 0, FC_NONE);
    add(0, OP_JMP,  0, 8'h00, 16'h0010, 16'h0010, 0, 0, FC_NONE);
    add(0, OP_BRZ,  0, 8'hF8, 16'h0000, 16'h0011, 0, 0, FC_NONE);
    add(0, OP_BRNZ, 0, 8'h05, 16'h0000, 16'h0016, 0, 0, FC_NONE);
    add(0, OP_BRNZ, 1, 8'h05, 16'h0000, 16'h0017, 0, 0, FC_NONE);
    add(0, OP_JMP,  0, 8'h00, 16'hFFFF, 16'hFFFF, 0, 0, FC_NONE);
    add(0, OP_INC,  0, 8'h00, 16'h0000, 16'h0000, 0, 0, FC_NONE);
    add(0, OP_JMP,  0, 8'h00, 16'h0001, 16'h0001, 0, 0, FC_NONE);
    add(0, OP_BRZ,  1, 8'hFE, 16'h0000, 16'hFFFF, 0, 0, FC_NONE);
    add(0, OP_NOP,  0, 8'h00, 16'h1234, 16'hFFFF, 0, 0, FC_NONE);
    add(0, OP_RSVD, 0, 8'h00, 16'h1234, 16'h0000, 0, 0, FC_NONE);
    add(0, OP_JMP,  0, 8'h00, 16'h0020, 16'h0020, 0, 0, FC_NONE);
    add(0, OP_CALL, 0, 8'h00, 16'h0100, 16'h0100, 1, 0, FC_NONE);
    add(0, OP_INC,  0, 8'h00, 16'h0000, 16'h0101, 1, 0, FC_NONE);
    add(0, OP_RET,  0, 8'h00, 16'h0000, 16'h0021, 0, 0, FC_NONE);
    add(0, OP_JMP,  0, 8'h00, 16'hFFFF, 16'hFFFF, 0, 0, FC_NONE);
    add(0, OP_CALL, 0, 8'h00, 16'h0200, 16'h0200, 1, 0, FC_NONE);
    add(0, OP_RET,  0, 8'h00, 16'h0000, 16'h0000, 0, 0, FC_NONE);
    add(1, OP_JMP,  0, 8'h00, 16'h0ABC, 16'h0000, 0, 0, FC_NONE);
    add(1, OP_JMP,  0, 8'h00, 16'h0ABC, 16'h0000, 0, 0, FC_NONE);
    add(1, OP_JMP,  0, 8'h00, 16'h0ABC, 16'h0000, 0, 0, FC_NONE);
    add(0, OP_JMP,  0, 8'h00, 16'h0050, 16'h0050, 0, 0, FC_NONE);
    add(0, OP_CALL, 0, 8'h00, 16'h1000, 16'h1000, 1, 0, FC_NONE);
    add(0, OP_CALL, 0, 8'h00, 16'h2000, 16'h2000, 2, 0, FC_NONE);
    add(1, OP_CALL, 0, 8'h00, 16'h7000, 16'h2000, 2, 0, FC_NONE);
    add(0, OP_CALL, 0, 8'h00, 16'h3000, 16'h3000, 3, 0, FC_NONE);
    add(0, OP_CALL, 0, 8'h00, 16'h4000, 16'h4000, 4, 0, FC_NONE);
    add(0, OP_RET,  0, 8'h00, 16'h0000, 16'h3001, 3, 0, FC_NONE);
    add(0, OP_CALL, 0, 8'h00, 16'h4000, 16'h4000, 4, 0, FC_NONE);
    add(0, OP_CALL, 0, 8'h00, 16'h5000, 16'h4000, 4, 1, FC_OVERFLOW);
    add(0, OP_JMP,  0, 8'h00, 16'h0ABC, 16'h4000, 4, 1, FC_OVERFLOW);
    add(0, OP_RET,  0, 8'h00, 16'h0000, 16'h4000, 4, 1, FC_OVERFLOW);
    add(1, OP_INC,  0, 8'h00, 16'h0000, 16'h4000, 4, 1, FC_OVERFLOW);

    // Power-on reset, BOOT cycle, then three increments.
    #2 reset = 1'b0;
    #1 chk_state("por", 16'h0000, 3'd0, 1'b0, FC_NONE);
    @(negedge clk);
    @(negedge clk);
    op    = OP_INC;
    reset = 1'b1;
    @(negedge clk);
    chk_state("boot", 16'h0000, 3'd0, 1'b0, FC_NONE);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk(16'(i) == 16'h0 ? "inc" : $sformatf("inc%0d pc", i), 32'(instr_addr), i);
    end

    for (int i = 0; i < n_vecs; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Return with an empty stack.
    do_reset("rst_a");
    v = '{0, OP_RET, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, FC_UNDERFLOW};
    apply(v, "underflow");
    v = '{0, OP_INC, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, FC_UNDERFLOW};
    apply(v, "underflow_hold");

    // Async reset while stalled with a live stack entry.
    do_reset("rst_b");
    v = '{0, OP_JMP, 0, 8'h00, 16'h0123, 16'h0123, 0, 0, FC_NONE};
    apply(v, "pre_jmp");
    v = '{0, OP_CALL, 0, 8'h00, 16'h0200, 16'h0200, 1, 0, FC_NONE};
    apply(v, "pre_call");
    for (int i = 0; i < 3; i++) begin
      v = '{1, OP_JMP, 0, 8'h00, 16'h0ABC, 16'h0200, 1, 0, FC_NONE};
      apply(v, $sformatf("stall%0d", i));
    end
    #3 reset = 1'b0;
    #1 chk_state("stall_rst", 16'h0000, 3'd0, 1'b0, FC_NONE);
    @(negedge clk);
    stall = 1'b0;
    op    = OP_INC;
    reset = 1'b1;
    @(negedge clk);
    chk_state("post_boot", 16'h0000, 3'd0, 1'b0, FC_NONE);
    @(negedge clk);
    chk_state("post_inc", 16'h0001, 3'd0, 1'b0, FC_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
